seg7_scan_driver: RTL

Parametrised time-multiplexed 7-segment display driver for NUM_DIGITS common-anode digits. It adds synchronous reset, per-digit blanking and decimal points, PWM brightness control, and a frame-synchronised double-buffered load so that digit updates never tear mid-frame. It sits between the application datapath (counters and rolling-text generators) and the board's anode/cathode pins.

---
 rtl/seg7_pkg.sv | 24 ++
 rtl/hex_to_seg7.sv | 15 +
 rtl/seg7_scan_driver.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared constants for the 7-segment scan driver: the hex -> segment table
// (active-high, segment a at bit 6 down to g at bit 0), the all-dark cathode
// pattern, and a helper that returns the active-low pattern for a nibble.
package seg7_pkg;

  // All segments dark on an active-low cathode bus.
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-high patterns, index = hex value, bit 6 = a ... bit 0 = g.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79,
    7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F,
    7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  // Common-anode boards sink current on the cathode, so the pins want the
  // inverted pattern.
  function automatic logic [6:0] seg7_active_low(input logic [3:0] nib);
    return ~SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7
// Combinational nibble -> active-low 7-segment decoder.
// Ports:
//   i_nibble  in   4  hex value to show
//   o_seg_n   out  7  active-low segments a..g, a at bit 6
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg_n
);

  assign o_seg_n = seg7_active_low(i_nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits with
// per-digit blanking and decimal points, PWM brightness, and a double-buffered
// load that only changes the displayed data at a frame boundary.
//
// Ports:
//   clk          in   1             system clock
//   rst          in   1             synchronous, active-high reset
//   digits_in    in   4*NUM_DIGITS  hex nibble per digit, digit i = [4i+3:4i]
//   dp_in        in   NUM_DIGITS    decimal point per digit, 1 = lit
//   blank_in     in   NUM_DIGITS    1 = digit dark
//   load         in   1             capture strobe for digits_in/dp_in/blank_in
//   bright       in   BRIGHT_W      brightness code, 0 = off, all-ones = full
//   anode        out  NUM_DIGITS    active-low digit enables
//   cathode      out  7             active-low segments a..g, a at bit 6
//   dp           out  1             active-low decimal point
//   frame_start  out  1             one-cycle pulse when digit 0 is first shown
//
// Load protocol: load is a single-cycle strobe with no back-pressure. Every
// cycle it is high the three data inputs are sampled; the most recent sample
// is what reaches the display at the next frame boundary.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int DIV        = 50000,
  parameter int BRIGHT_W   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
  input  logic [BRIGHT_W-1:0]     bright,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              cathode,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int PCNT_W = $clog2(DIV);
  // Threshold must be able to hold DIV itself (full-on).
  localparam int THR_W  = $clog2(DIV + 1);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [THR_W-1:0]  THR_FULL  = THR_W'(DIV);
  localparam logic [THR_W-1:0]  STEP      = THR_W'(DIV >> BRIGHT_W);

  // Scan state
  logic [PCNT_W-1:0] r_pcnt;
  logic [IDX_W-1:0]  r_idx;
  logic [THR_W-1:0]  r_thr;

  // Shadow (written by load) and active (shown) data
  logic                    r_pending;
  logic [4*NUM_DIGITS-1:0] r_sh_digits;
  logic [NUM_DIGITS-1:0]   r_sh_dp;
  logic [NUM_DIGITS-1:0]   r_sh_blank;
  logic [4*NUM_DIGITS-1:0] r_act_digits;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic [NUM_DIGITS-1:0]   r_act_blank;

  // Registered pin drivers
  logic [NUM_DIGITS-1:0] r_anode;
  logic [6:0]            r_cathode;
  logic                  r_dp;
  logic                  r_frame_start;

  logic                  w_tick;
  logic                  w_boundary;
  logic [THR_W-1:0]      w_thr_next;
  logic                  w_on;
  logic                  w_lit;
  logic [3:0]            w_nibble;
  logic [6:0]            w_seg_n;
  logic [NUM_DIGITS-1:0] w_digit_sel;

  assign w_tick     = (r_pcnt == PCNT_LAST);
  assign w_boundary = w_tick && (r_idx == IDX_LAST);

  // All-ones is special-cased to DIV so full brightness has no dark gap even
  // when DIV is not an exact multiple of 2^BRIGHT_W.
  assign w_thr_next = (&bright) ? THR_FULL : THR_W'(bright) * STEP;

  assign w_on        = (THR_W'(r_pcnt) < r_thr);
  assign w_lit       = w_on && !r_act_blank[r_idx];
  assign w_nibble    = r_act_digits[{r_idx, 2'b00} +: 4];
  assign w_digit_sel = NUM_DIGITS'(1) << r_idx;

  hex_to_seg7 u_dec (
    .i_nibble (w_nibble),
    .o_seg_n  (w_seg_n)
  );

  // Prescaler, digit index and per-slot brightness threshold. The threshold
  // is only sampled on a tick so a brightness change never alters the slot
  // already in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcnt <= '0;
      r_idx  <= '0;
      r_thr  <= '0;
    end else if (w_tick) begin
      r_pcnt <= '0;
      r_thr  <= w_thr_next;
      r_idx  <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_pcnt <= r_pcnt + 1'b1;
    end
  end

  // Shadow capture and frame-synchronous transfer to the active copy.
  // A load on the boundary cycle itself bypasses the shadow so it is shown
  // from the very next slot instead of waiting a whole frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending    <= 1'b0;
      r_sh_digits  <= '0;
      r_sh_dp      <= '0;
      r_sh_blank   <= '0;
      r_act_digits <= '0;
      r_act_dp     <= '0;
      r_act_blank  <= '1;
    end else begin
      if (load) begin
        r_sh_digits <= digits_in;
        r_sh_dp     <= dp_in;
        r_sh_blank  <= blank_in;
      end

      if (w_boundary) begin
        r_pending <= 1'b0;
        if (load) begin
          r_act_digits <= digits_in;
          r_act_dp     <= dp_in;
          r_act_blank  <= blank_in;
        end else if (r_pending) begin
          r_act_digits <= r_sh_digits;
          r_act_dp     <= r_sh_dp;
          r_act_blank  <= r_sh_blank;
        end
      end else if (load) begin
        r_pending <= 1'b1;
      end
    end
  end

  // Output stage: one register between scan state and the pins so the pins
  // are glitch-free. frame_start marks the first pin cycle of digit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_anode       <= '1;
      r_cathode     <= SEG_OFF;
      r_dp          <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= (r_idx == '0) && (r_pcnt == '0);
      if (w_lit) begin
        r_anode   <= ~w_digit_sel;
        r_cathode <= w_seg_n;
        r_dp      <= ~r_act_dp[r_idx];
      end else begin
        r_anode   <= '1;
        r_cathode <= SEG_OFF;
        r_dp      <= 1'b1;
      end
    end
  end

  assign anode       = r_anode;
  assign cathode     = r_cathode;
  assign dp          = r_dp;
  assign frame_start = r_frame_start;

endmodule
